// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter:
// ALU opcodes and the request/response FSM states.
package alu_share_arbiter_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_NOR = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0011;
   localparam logic [3:0] OP_SUB = 4'b0100;
   localparam logic [3:0] OP_LUI = 4'b0101;
   localparam logic [3:0] OP_SRL = 4'b1110;
   localparam logic [3:0] OP_SLL = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid request
// at or after rr_ptr, wrapping NUM_REQ-1 -> 0.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(NUM_REQ))
            sum = sum - (IDX_W+1)'(NUM_REQ);
         idx = sum[IDX_W-1:0];
         if (!grant_any && req_valid[idx]) begin
            grant_any  = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one 32-bit ALU among NUM_REQ requesters with a
// round-robin grant; one operation in flight at a time.
module alu_share_arbiter
   import alu_share_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [4*NUM_REQ-1:0]  req_op,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [5*NUM_REQ-1:0]  req_shamt,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [31:0]           rsp_result,
   output logic                  rsp_zero,
   output logic [IDX_W-1:0]      rsp_id,
   output logic [3:0]            alu_operation,
   output logic [31:0]           alu_a,
   output logic [31:0]           alu_b,
   output logic [4:0]            alu_shamt,
   input  logic [31:0]           alu_result,
   input  logic                  alu_zero
);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   rr_ptr_q;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;
   logic               accept;
   logic [3:0]         sel_op;
   logic [31:0]        sel_a;
   logic [31:0]        sel_b;
   logic [4:0]         sel_shamt;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_arb (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (gnt),
      .grant_idx (gnt_idx),
      .grant_any (gnt_any)
   );

   assign accept = (state_q == IDLE) && gnt_any;

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE)
         req_ready = gnt;
   end

   // Operand mux steered by the one-hot grant
   always_comb begin
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      sel_shamt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            sel_op    = req_op[4*i +: 4];
            sel_a     = req_a[32*i +: 32];
            sel_b     = req_b[32*i +: 32];
            sel_shamt = req_shamt[5*i +: 5];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: if (rsp_ready[rsp_id]) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         alu_operation <= OP_AND;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_shamt     <= '0;
         rsp_id        <= '0;
         rsp_valid     <= '0;
         rsp_result    <= '0;
         rsp_zero      <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            alu_operation <= sel_op;
            alu_a         <= sel_a;
            alu_b         <= sel_b;
            alu_shamt     <= sel_shamt;
            rsp_id        <= gnt_idx;
            rr_ptr_q      <= (gnt_idx == IDX_W'(NUM_REQ-1))
                             ? '0 : gnt_idx + 1'b1;
         end
         if (state_q == EXEC) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_valid  <= NUM_REQ'(1) << rsp_id;
         end else if (state_q == RESP && rsp_ready[rsp_id]) begin
            rsp_valid  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a behavioural ALU
// drives alu_result; a queue model predicts grant order and results.
module tb_alu_share_arbiter;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [4*N-1:0]  req_op;
   logic [32*N-1:0] req_a, req_b;
   logic [5*N-1:0]  req_shamt;
   logic [31:0]     rsp_result;
   logic            rsp_zero;
   logic [IW-1:0]   rsp_id;
   logic [3:0]      alu_operation;
   logic [31:0]     alu_a, alu_b, alu_result;
   logic [4:0]      alu_shamt;
   logic            alu_zero;

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        z;
   } exp_t;

   exp_t        q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          ptr   = 0;
   int          mode  = 2;
   logic [3:0]  op_t[N];
   logic [31:0] a_t[N];
   logic [31:0] b_t[N];
   logic [4:0]  sh_t[N];

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(N), .IDX_W(IW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_a(req_a), .req_b(req_b),
      .req_shamt(req_shamt),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero),
      .rsp_id(rsp_id),
      .alu_operation(alu_operation), .alu_a(alu_a),
      .alu_b(alu_b), .alu_shamt(alu_shamt),
      .alu_result(alu_result), .alu_zero(alu_zero)
   );

   function automatic logic [31:0] model_alu(
      input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b, input logic [4:0] sh);
      case (op)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return ~(a | b);
         4'd3:    return a + b;
         4'd4:    return a - b;
         4'd5:    return {b[15:0], 16'h0000};
         4'd14:   return b >> sh;
         4'd15:   return b << sh;
         default: return 32'h0;
      endcase
   endfunction

   assign alu_result = model_alu(alu_operation, alu_a, alu_b, alu_shamt);
   assign alu_zero   = (alu_result == 32'h0);

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got timeout expected completion", nm);
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_req_ready"}, 64'(req_ready), 64'h0);
      chk({nm, "_rsp_valid"}, 64'(rsp_valid), 64'h0);
      chk({nm, "_rsp_result"}, 64'(rsp_result), 64'h0);
      chk({nm, "_alu_ab"}, {alu_a, alu_b}, 64'h0);
      chk({nm, "_misc"},
          64'({alu_operation, alu_shamt, rsp_zero, rsp_id}), 64'h0);
   endtask

   task automatic set_req(input int i, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
      op_t[i] = op;
      a_t[i]  = a;
      b_t[i]  = b;
      sh_t[i] = sh;
      req_op[4*i +: 4]     = op;
      req_a[32*i +: 32]    = a;
      req_b[32*i +: 32]    = b;
      req_shamt[5*i +: 5]  = sh;
   endtask

   task automatic push_exp(input int i);
      logic [31:0] r;
      r = model_alu(op_t[i], a_t[i], b_t[i], sh_t[i]);
      q.push_back('{i, r, (r == 32'h0)});
   endtask

   task automatic drain();
      int budget = 0;
      while (q.size() != 0 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (q.size() != 0) begin
         fail("rsp_timeout");
         q.delete();
      end
   endtask

   // All requesters in mask are raised together; they are served in
   // rotating order starting at the model pointer.
   task automatic issue(input logic [N-1:0] mask);
      int          last = 0;
      int          budget = 0;
      logic [N-1:0] acc;
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         int i = (ptr + k) % N;
         if (mask[i]) begin
            push_exp(i);
            last = i;
         end
      end
      ptr = (last + 1) % N;
      req_valid = mask;
      while (req_valid != 0 && budget < 200) begin
         #1 acc = req_valid & req_ready;
         @(posedge clk);
         #1 req_valid = req_valid & ~acc;
         budget++;
         if (req_valid != 0) @(negedge clk);
      end
      if (req_valid != 0) begin
         fail("grant_timeout");
         req_valid = '0;
      end
      drain();
   endtask

   // Monitor: a new response is rsp_valid rising from zero
   initial begin : monitor
      logic [N-1:0] prev;
      logic [34:0]  held;
      exp_t         e;
      prev = '0;
      held = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev = '0;
         end else begin
            if (rsp_valid != 0) begin
               if (prev == 0) begin
                  if (q.size() == 0) begin
                     n_cmp++;
                     n_err++;
                     $display("FAIL unexpected_rsp: got id %0d expected none",
                              rsp_id);
                  end else begin
                     e = q.pop_front();
                     chk("rsp_id", 64'(rsp_id), 64'(e.id));
                     chk("rsp_onehot", 64'(rsp_valid), 64'(1) << e.id);
                     chk("rsp_result", 64'(rsp_result), 64'(e.res));
                     chk("rsp_zero", 64'(rsp_zero), 64'(e.z));
                  end
                  held = {rsp_id, rsp_result, rsp_zero};
               end else begin
                  chk("rsp_stable", 64'({rsp_id, rsp_result, rsp_zero}),
                      64'(held));
                  chk("rsp_valid_stable", 64'(rsp_valid), 64'(prev));
               end
            end
            prev = rsp_valid;
         end
         if (mode == 0) rsp_ready = N'($urandom);
         else if (mode == 1) rsp_ready = '1;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [N-1:0] m;
      reset     = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      req_shamt = '0;
      for (int i = 0; i < N; i++) set_req(i, 4'd0, 32'd0, 32'd0, 5'd0);
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check_reset_outputs("idle");
      end

      // ADD 5+7 on req0 with exact latency
      @(negedge clk);
      set_req(0, 4'd3, 32'd5, 32'd7, 5'd0);
      req_valid = 4'b0001;
      push_exp(0);
      ptr = 1;
      #1 chk("t2_grant", 64'(req_ready), 64'h1);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("t2_exec_no_rsp", 64'(rsp_valid), 64'h0);
      @(negedge clk);
      chk("t2_rsp", 64'(rsp_valid), 64'h1);
      rsp_ready = 4'b0001;
      @(negedge clk);
      chk("t2_rsp_clear", 64'(rsp_valid), 64'h0);
      rsp_ready = '0;

      // SUB 9-9 on req1 held unacknowledged; req3 must wait
      @(negedge clk);
      set_req(1, 4'd4, 32'd9, 32'd9, 5'd0);
      req_valid = 4'b0010;
      rsp_ready = 4'b1101;
      push_exp(1);
      @(posedge clk);
      #1 set_req(3, 4'd3, 32'd1, 32'd1, 5'd0);
      req_valid = 4'b1000;
      push_exp(3);
      ptr = 0;
      @(negedge clk);
      @(negedge clk);
      repeat (5) begin
         chk("t3_no_grant", 64'(req_ready), 64'h0);
         chk("t3_hold_valid", 64'(rsp_valid), 64'h2);
         chk("t3_hold_res", 64'({rsp_result, rsp_zero}), 64'h1);
         @(negedge clk);
      end
      rsp_ready = 4'b0010;
      @(negedge clk);
      #1 chk("t3_next_grant", 64'(req_ready), 64'h8);
      @(posedge clk);
      #1 req_valid = '0;
      rsp_ready = '0;
      mode = 1;
      drain();

      // All four contend, then req0 again: order 0,1,2,3,0
      for (int i = 0; i < N; i++)
         set_req(i, 4'($urandom_range(0, 5)), $urandom, $urandom,
                 5'($urandom));
      set_req(2, 4'd5, $urandom, 32'h0000_1234, 5'd0);
      issue(4'b1111);
      set_req(0, 4'd3, $urandom, $urandom, 5'd0);
      issue(4'b0001);

      // Shift boundaries and undefined opcode
      set_req(3, 4'd15, $urandom, 32'h1, 5'd31);
      issue(4'b1000);
      set_req(3, 4'd14, $urandom, 32'h8000_0000, 5'd31);
      issue(4'b1000);
      set_req(3, 4'd6, $urandom, $urandom, 5'($urandom));
      issue(4'b1000);

      // Random traffic with random response back-pressure
      mode = 0;
      repeat (60) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            logic [31:0] a;
            a = $urandom;
            set_req(i, 4'($urandom_range(0, 15)), a,
                    ($urandom_range(0, 3) == 0) ? a : $urandom,
                    5'($urandom));
         end
         issue(m);
      end

      // Reset in EXEC discards the op and restarts the pointer
      mode = 1;
      repeat (4) @(negedge clk);
      mode = 2;
      rsp_ready = '0;
      @(negedge clk);
      set_req(2, 4'd3, 32'd3, 32'd4, 5'd0);
      req_valid = 4'b0100;
      @(posedge clk);
      #1 req_valid = '0;
      #1 reset = 1'b1;
      #1 check_reset_outputs("t6_async");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mode = 1;
      repeat (4) begin
         @(negedge clk);
         chk("t6_no_rsp", 64'(rsp_valid), 64'h0);
      end
      ptr = 0;
      set_req(0, 4'd1, $urandom, $urandom, 5'd0);
      set_req(3, 4'd2, $urandom, $urandom, 5'd0);
      issue(4'b1001);

      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
